// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: scoreboard entry, forwarding
// encodings and stage indices.
package pipe_pkg;

  // Scoreboard rd is stored at a fixed width so the struct is parameter-free;
  // NREG up to 256 is supported.
  localparam int TRK_AW = 8;

  typedef struct packed {
    logic              v;
    logic [TRK_AW-1:0] rd;
    logic              wr;
    logic              ld;
  } stage_trk_t;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;
  localparam int NSTG    = 3;

  function automatic logic trk_hit(stage_trk_t t, logic [TRK_AW-1:0] rs);
    return t.v & t.wr & (t.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_port_cmp.sv
// One source-port comparator: picks the youngest in-flight producer of rs and
// flags a load-use hazard when that producer is a load still in EX.
module hazard_port_cmp
  import pipe_pkg::*;
#(
  parameter int AW        = 5,
  parameter int WB_BYPASS = 0
) (
  input  logic          active,
  input  logic [AW-1:0] rs,
  input  stage_trk_t    ex,
  input  stage_trk_t    mem,
  input  stage_trk_t    wb,
  output logic [1:0]    fwd,
  output logic          luse
);

  logic [TRK_AW-1:0] rs_x;
  logic              unused_ld;

  assign rs_x      = TRK_AW'(rs);
  // Only the EX producer's load flag matters; MEM data covers loads already.
  assign unused_ld = mem.ld ^ wb.ld;

  always_comb begin
    fwd  = FWD_RF;
    luse = 1'b0;
    if (active) begin
      if (trk_hit(ex, rs_x)) begin
        if (ex.ld) luse = 1'b1;
        else       fwd  = FWD_EX;
      end else if (trk_hit(mem, rs_x)) begin
        fwd = FWD_MEM;
      end else if (trk_hit(wb, rs_x) && (WB_BYPASS == 0)) begin
        fwd = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush controller for the 5-stage pipe.
// Optional HAZARD_PERF_EN adds saturating stall/flush event counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int NREG      = 32,
  parameter int NRD       = 2,
  parameter int WB_BYPASS = 0,
  localparam int AW       = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [NRD*AW-1:0] id_rs,
  input  logic [NRD-1:0]    id_rs_used,
  input  logic [AW-1:0]     id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_branch_taken,
  input  logic              mem_busy,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              bubble_idex,
  output logic              flush_ifid,
  output logic              freeze,
  output logic [NRD*2-1:0]  fwd_sel
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  stage_trk_t     sb [NSTG];
  stage_trk_t     id_trk;
  logic [NRD-1:0] luse_vec;
  logic           luse;
  logic           issue;

  for (genvar g = 0; g < NRD; g++) begin : g_port
    hazard_port_cmp #(.AW(AW), .WB_BYPASS(WB_BYPASS)) u_cmp (
      .active (id_valid & id_rs_used[g] & (id_rs[g*AW +: AW] != '0)),
      .rs     (id_rs[g*AW +: AW]),
      .ex     (sb[STG_EX]),
      .mem    (sb[STG_MEM]),
      .wb     (sb[STG_WB]),
      .fwd    (fwd_sel[g*2 +: 2]),
      .luse   (luse_vec[g])
    );
  end

  assign luse        = |luse_vec;
  assign freeze      = mem_busy;
  assign issue       = id_valid & ~luse;
  assign stall_pc    = luse | freeze;
  assign stall_ifid  = luse | freeze;
  assign bubble_idex = luse & ~freeze;
  // A pending load-use wins over a taken branch; the branch re-resolves next cycle.
  assign flush_ifid  = id_valid & id_branch_taken & ~luse & ~freeze;

  always_comb begin
    id_trk    = '0;
    id_trk.v  = 1'b1;
    id_trk.rd = TRK_AW'(id_rd);
    id_trk.wr = id_reg_write & (id_rd != '0);
    id_trk.ld = id_mem_read;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NSTG; s++) sb[s] <= '0;
    end else if (!freeze) begin
      sb[STG_WB]  <= sb[STG_MEM];
      sb[STG_MEM] <= sb[STG_EX];
      sb[STG_EX]  <= issue ? id_trk : '0;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bubble_idex && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (flush_ifid  && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic, checked
// against a producer-history model (WB_BYPASS=0 and =1 instances side by side).
module tb_pipe_hazard_ctrl;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          id_valid = 1'b0;
  logic [AW-1:0] rs0 = '0, rs1 = '0, rd = '0;
  logic [1:0]    used = '0;
  logic          rw = 1'b0, ld = 1'b0, br = 1'b0, busy = 1'b0;
  logic [NRD*AW-1:0] id_rs;
  assign id_rs = {rs1, rs0};

  logic       d0_stall_pc, d0_stall_ifid, d0_bubble, d0_flush, d0_freeze;
  logic       d1_stall_pc, d1_stall_ifid, d1_bubble, d1_flush, d1_freeze;
  logic [3:0] d0_fwd, d1_fwd;
`ifdef HAZARD_PERF_EN
  logic [31:0] d0_scnt, d0_fcnt, d1_scnt, d1_fcnt;
`endif

  pipe_hazard_ctrl #(.NREG(NREG), .NRD(NRD), .WB_BYPASS(0)) dut0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(used),
    .id_rd(rd), .id_reg_write(rw), .id_mem_read(ld), .id_branch_taken(br), .mem_busy(busy),
    .stall_pc(d0_stall_pc), .stall_ifid(d0_stall_ifid), .bubble_idex(d0_bubble),
    .flush_ifid(d0_flush), .freeze(d0_freeze), .fwd_sel(d0_fwd)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(d0_scnt), .flush_cnt(d0_fcnt)
`endif
  );

  pipe_hazard_ctrl #(.NREG(NREG), .NRD(NRD), .WB_BYPASS(1)) dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(used),
    .id_rd(rd), .id_reg_write(rw), .id_mem_read(ld), .id_branch_taken(br), .mem_busy(busy),
    .stall_pc(d1_stall_pc), .stall_ifid(d1_stall_ifid), .bubble_idex(d1_bubble),
    .flush_ifid(d1_flush), .freeze(d1_freeze), .fwd_sel(d1_fwd)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(d1_scnt), .flush_cnt(d1_fcnt)
`endif
  );

  int npass = 0;
  int nchk  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Model: history of what entered EX, newest first; index = instructions back.
  typedef struct {bit v; int rd; bit wr; bit ld;} rec_t;
  rec_t hist[$];
  logic [3:0]  e_fwd0, e_fwd1;
  bit          e_luse, e_stall, e_bub, e_flush;
  int unsigned m_scnt, m_fcnt;

  function automatic void model_clear();
    rec_t z;
    z = '{v: 0, rd: 0, wr: 0, ld: 0};
    hist.delete();
    for (int k = 0; k < 3; k++) hist.push_back(z);
    m_scnt = 0;
    m_fcnt = 0;
  endfunction

  task automatic eval_chk();
    int src;
    logic [1:0] f0, f1;
    #1;
    e_luse = 0; e_fwd0 = '0; e_fwd1 = '0;
    for (int p = 0; p < NRD; p++) begin
      src = (p == 0) ? int'(rs0) : int'(rs1);
      f0 = 2'd0; f1 = 2'd0;
      if (id_valid && used[p] && src != 0) begin
        for (int k = 0; k < 3; k++) begin
          if (hist[k].v && hist[k].wr && hist[k].rd == src) begin
            if (k == 0) begin
              if (hist[k].ld) e_luse = 1;
              else begin f0 = 2'd1; f1 = 2'd1; end
            end else if (k == 1) begin
              f0 = 2'd2; f1 = 2'd2;
            end else begin
              f0 = 2'd3; f1 = 2'd0;
            end
            break;
          end
        end
      end
      e_fwd0[p*2 +: 2] = f0;
      e_fwd1[p*2 +: 2] = f1;
    end
    e_stall = e_luse | busy;
    e_bub   = e_luse & ~busy;
    e_flush = id_valid & br & ~e_luse & ~busy;
    chk("fwd_sel",     d0_fwd,        e_fwd0);
    chk("fwd_sel_byp", d1_fwd,        e_fwd1);
    chk("stall_pc",    d0_stall_pc,   e_stall);
    chk("stall_ifid",  d0_stall_ifid, e_stall);
    chk("bubble_idex", d0_bubble,     e_bub);
    chk("flush_ifid",  d0_flush,      e_flush);
    chk("freeze",      d0_freeze,     busy);
    chk("stall_byp",   d1_stall_pc,   e_stall);
`ifdef HAZARD_PERF_EN
    chk("stall_cnt", d0_scnt, m_scnt);
    chk("flush_cnt", d0_fcnt, m_fcnt);
`endif
  endtask

  task automatic adv();
    rec_t r;
    @(posedge clk);
    if (reset) begin
      if (e_bub && m_scnt != 32'hFFFF_FFFF) m_scnt++;
      if (e_flush && m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
      if (!busy) begin
        r = '{v: id_valid && !e_luse, rd: int'(rd), wr: rw, ld: ld};
        hist.push_front(r);
        void'(hist.pop_back());
      end
    end
    @(negedge clk);
  endtask

  task automatic set_in(input bit v, input int a, input int b, input bit [1:0] u,
                        input int d, input bit w, input bit l, input bit bt, input bit bz);
    id_valid = v; rs0 = a[AW-1:0]; rs1 = b[AW-1:0]; used = u;
    rd = d[AW-1:0]; rw = w; ld = l; br = bt; busy = bz;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    @(negedge clk);
    // Reset held: no forwarding or stall, flush and freeze follow inputs.
    set_in(1, 3, 0, 2'b01, 3, 1, 0, 1, 0);
    eval_chk();
    chk("rst_flush", d0_flush, 1'b1);
    chk("rst_fwd",   d0_fwd,   4'd0);
    adv();
    set_in(1, 3, 0, 2'b01, 3, 1, 1, 0, 1);
    eval_chk();
    chk("rst_freeze", d0_freeze, 1'b1);
    adv();
    reset = 1'b1;

    // EX forward
    set_in(1, 1, 2, 2'b11, 3, 1, 0, 0, 0); eval_chk(); adv();
    set_in(1, 3, 1, 2'b11, 4, 1, 0, 0, 0); eval_chk();
    chk("ex_fwd", d0_fwd, 4'b0001);
    chk("ex_nostall", d0_stall_pc, 1'b0);
    adv();

    // Load-use: one stall cycle, then MEM forwarding on both ports
    set_in(1, 0, 0, 2'b00, 5, 1, 1, 0, 0); eval_chk(); adv();
    set_in(1, 5, 5, 2'b11, 6, 1, 0, 0, 0); eval_chk();
    chk("lu_stall", d0_stall_pc, 1'b1);
    chk("lu_bubble", d0_bubble, 1'b1);
    chk("lu_fwd", d0_fwd, 4'd0);
    adv();
    eval_chk();
    chk("lu_memfwd", d0_fwd, 4'b1010);
    chk("lu_release", d0_stall_pc, 1'b0);
    adv();

    // r0 destination never forwards
    set_in(1, 1, 1, 2'b11, 0, 1, 1, 0, 0); eval_chk(); adv();
    set_in(1, 0, 0, 2'b11, 7, 1, 0, 0, 0); eval_chk();
    chk("r0_fwd", d0_fwd, 4'd0);
    chk("r0_stall", d0_stall_pc, 1'b0);
    adv();

    // Branch alone, then branch colliding with load-use
    set_in(1, 0, 0, 2'b00, 0, 0, 0, 1, 0); eval_chk();
    chk("br_flush", d0_flush, 1'b1);
    adv();
    set_in(1, 0, 0, 2'b00, 0, 0, 0, 0, 0); eval_chk();
    chk("br_once", d0_flush, 1'b0);
    adv();
    set_in(1, 0, 0, 2'b00, 9, 1, 1, 0, 0); eval_chk(); adv();
    set_in(1, 9, 0, 2'b01, 0, 0, 0, 1, 0); eval_chk();
    chk("brlu_noflush", d0_flush, 1'b0);
    chk("brlu_stall", d0_stall_pc, 1'b1);
    adv();
    eval_chk();
    chk("brlu_flush", d0_flush, 1'b1);
    chk("brlu_fwd", d0_fwd[1:0], 2'd2);
    adv();

    // Freeze with producer in MEM
    set_in(1, 0, 0, 2'b00, 10, 1, 0, 0, 0); eval_chk(); adv();
    set_in(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);  eval_chk(); adv();
    for (int c = 0; c < 3; c++) begin
      set_in(1, 10, 0, 2'b01, 14, 1, 0, 0, 1); eval_chk();
      chk("frz_freeze", d0_freeze, 1'b1);
      chk("frz_fwd", d0_fwd[1:0], 2'd2);
      chk("frz_nobubble", d0_bubble, 1'b0);
      adv();
    end
    set_in(1, 10, 0, 2'b01, 14, 1, 0, 0, 0); eval_chk();
    chk("frz_after", d0_fwd[1:0], 2'd2);
    adv();

    // Producer three back: WB forward vs write-through bypass
    set_in(1, 0, 0, 2'b00, 11, 1, 0, 0, 0); eval_chk(); adv();
    set_in(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);  eval_chk(); adv();
    set_in(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);  eval_chk(); adv();
    set_in(1, 0, 11, 2'b10, 0, 0, 0, 0, 0); eval_chk();
    chk("wb_fwd", d0_fwd[3:2], 2'd3);
    chk("wb_bypass", d1_fwd[3:2], 2'd0);
    adv();

    // Reset during a load-use stall
    set_in(1, 0, 0, 2'b00, 12, 1, 1, 0, 0); eval_chk(); adv();
    set_in(1, 12, 0, 2'b01, 13, 1, 0, 0, 0); eval_chk();
    chk("rs_pre", d0_stall_pc, 1'b1);
    reset = 1'b0;
    model_clear();
    #1;
    chk("rs_stall", d0_stall_pc, 1'b0);
    chk("rs_bubble", d0_bubble, 1'b0);
    chk("rs_fwd", d0_fwd, 4'd0);
    adv();
    reset = 1'b1;
    eval_chk();
    chk("rs_nopersist", d0_stall_pc, 1'b0);
`ifdef HAZARD_PERF_EN
    chk("perf_zero", d0_scnt, 32'd0);
`endif
    adv();
    set_in(1, 0, 0, 2'b00, 15, 1, 1, 0, 0); eval_chk(); adv();
    set_in(1, 15, 0, 2'b01, 16, 1, 0, 0, 0); eval_chk(); adv();
`ifdef HAZARD_PERF_EN
    #1;
    chk("perf_one", d0_scnt, 32'd1);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        model_clear();
      end else begin
        reset = 1'b1;
      end
      set_in($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
             2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);
      eval_chk();
      adv();
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
